// File: rtl/sat_addsub_seq_pkg.sv
// sat_alu_pkg: shared mode and FSM state types for the sequential saturating add/sub unit.
package sat_alu_pkg;
  typedef enum logic [1:0] {MODE_ADD = 2'b00, MODE_SUB = 2'b01, MODE_PADD = 2'b10, MODE_ADDW = 2'b11} mode_t;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/sat_addsub_seq_if.sv
// sat_addsub_seq_if: start/ready/done request bus between the ALU and the add/sub engine.
interface sat_addsub_seq_if #(parameter int WIDTH = 16);
  import sat_alu_pkg::*;
  logic start;
  mode_t mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic ready;
  logic done;
  logic [WIDTH-1:0] result;
  logic n_flag;
  logic z_flag;
  logic v_flag;
  logic cout;
  modport master (output start, mode, a, b, input ready, done, result, n_flag, z_flag, v_flag, cout);
  modport slave (input start, mode, a, b, output ready, done, result, n_flag, z_flag, v_flag, cout);
endinterface

// File: rtl/sat_addsub_seq_lane.sv
// sat_lane_add: one combinational LANE_W-bit carry-lookahead lane with optional lane saturation.
module sat_lane_add #(parameter int LANE_W = 4) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              cin,
  input  logic              sat_en,
  output logic [LANE_W-1:0] sum,
  output logic              cout,
  output logic              ovf
);
  logic [LANE_W-1:0] g, p, raw;
  logic [LANE_W:0] c;
  assign g = a & b;
  assign p = a ^ b;
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < LANE_W; i++) c[i+1] = g[i] | (p[i] & c[i]);
  end
  assign raw  = p ^ c[LANE_W-1:0];
  assign cout = c[LANE_W];
  // signed overflow: carry into the sign bit differs from carry out of it
  assign ovf  = c[LANE_W] ^ c[LANE_W-1];
  assign sum  = (sat_en && ovf) ? (a[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}}) : raw;
endmodule

// File: rtl/sat_addsub_seq.sv
// sat_addsub_seq: multi-cycle signed saturating add/sub, one LANE_W lane per cycle, LSB lane first.
module sat_addsub_seq
  import sat_alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 4
) (
  input logic             clk,
  input logic             rst,
  sat_addsub_seq_if.slave bus
);
  localparam int N_LANES = WIDTH / LANE_W;
  localparam int IW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  if ((WIDTH % LANE_W) != 0 || LANE_W < 2) begin : g_bad_params
    $error("sat_addsub_seq: WIDTH must be a multiple of LANE_W and LANE_W >= 2");
  end
  state_t state_q, state_d;
  mode_t mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, psum_q, psum_d, result_q, result_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, n_q, n_d, z_q, z_d, v_q, v_d, c_q, c_d;
  logic [LANE_W-1:0] l_a, l_b, l_sum;
  logic l_cout, l_ovf, padd, last;
  assign padd = mode_q == MODE_PADD;
  assign last = idx_q == IW'(N_LANES - 1);
  assign l_a = a_q[int'(idx_q)*LANE_W +: LANE_W];
  assign l_b = b_q[int'(idx_q)*LANE_W +: LANE_W];
  sat_lane_add #(.LANE_W(LANE_W)) u_lane (
    .a(l_a), .b(l_b), .cin(padd ? 1'b0 : carry_q), .sat_en(padd),
    .sum(l_sum), .cout(l_cout), .ovf(l_ovf)
  );
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    psum_d   = psum_q;
    result_d = result_q;
    n_d      = n_q;
    z_d      = z_q;
    v_d      = v_q;
    c_d      = c_q;
    if (state_q == IDLE) begin
      if (bus.start) begin
        state_d = RUN;
        mode_d  = bus.mode;
        a_d     = bus.a;
        // SUB is a + ~b + 1: store ~b and seed the carry chain with 1
        b_d     = (bus.mode == MODE_SUB) ? ~bus.b : bus.b;
        idx_d   = '0;
        carry_d = bus.mode == MODE_SUB;
      end
    end else if (state_q == RUN) begin
      psum_d[int'(idx_q)*LANE_W +: LANE_W] = l_sum;
      carry_d = l_cout;
      idx_d   = idx_q + IW'(1);
      if (last) begin
        state_d  = DONE;
        result_d = (mode_q inside {MODE_ADD, MODE_SUB} && l_ovf) ?
                   (a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : psum_d;
        if (!padd) begin
          n_d = result_d[WIDTH-1];
          z_d = result_d == '0;
          v_d = l_ovf;
          c_d = l_cout;
        end
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= MODE_ADD;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      psum_q   <= '0;
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      psum_q   <= psum_d;
      result_q <= result_d;
      n_q      <= n_d;
      z_q      <= z_d;
      v_q      <= v_d;
      c_q      <= c_d;
    end
  end
  assign bus.ready  = state_q == IDLE;
  assign bus.done   = state_q == DONE;
  assign bus.result = result_q;
  assign bus.n_flag = n_q;
  assign bus.z_flag = z_q;
  assign bus.v_flag = v_q;
  assign bus.cout   = c_q;
endmodule

// File: tb/tb_sat_addsub_seq.sv
// tb_sat_addsub_seq: directed vectors with hand-computed results for sat_addsub_seq (16/4).
module tb_sat_addsub_seq;
  import sat_alu_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  sat_addsub_seq_if #(.WIDTH(16)) bus ();
  sat_addsub_seq #(.WIDTH(16), .LANE_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input mode_t m, input logic [15:0] x, input logic [15:0] y, output int lat, output logic rdy_low);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.a     = x;
    bus.b     = y;
    tick;
    bus.start = 1'b0;
    bus.a     = ~x;
    bus.b     = ~y;
    lat       = 0;
    rdy_low   = 1'b1;
    while (bus.done !== 1'b1 && lat < 20) begin
      rdy_low &= (bus.ready === 1'b0);
      tick;
      lat++;
    end
    rdy_low &= (bus.ready === 1'b0);
  endtask
  function automatic logic [3:0] flags();
    return {bus.n_flag, bus.z_flag, bus.v_flag, bus.cout};
  endfunction
  initial begin
    int lat;
    logic rl;
    int ndone;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.mode = MODE_ADD;
    bus.a = '0;
    bus.b = '0;
    tick;
    tick;
    chk("rst_ready", bus.ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags", flags(), 4'b0000);
    rst = 1'b0;
    tick;
    run(MODE_ADD, 16'h7FFF, 16'h0001, lat, rl);
    chk("add_sat_latency", lat, 4);
    chk("add_sat_ready_low", rl, 1);
    chk("add_sat_result", bus.result, 16'h7FFF);
    chk("add_sat_flags_nzvc", flags(), 4'b0010);
    tick;
    chk("add_sat_done_pulse", bus.done, 0);
    chk("add_sat_ready_back", bus.ready, 1);
    run(MODE_SUB, 16'h8000, 16'h0001, lat, rl);
    chk("sub_sat_result", bus.result, 16'h8000);
    chk("sub_sat_flags_nzvc", flags(), 4'b1011);
    tick;
    run(MODE_SUB, 16'h1234, 16'h1234, lat, rl);
    chk("sub_zero_result", bus.result, 16'h0000);
    chk("sub_zero_flags_nzvc", flags(), 4'b0101);
    tick;
    run(MODE_PADD, 16'h7F18, 16'h1188, lat, rl);
    chk("padd_latency", lat, 4);
    chk("padd_result", bus.result, 16'h7098);
    chk("padd_flags_held", flags(), 4'b0101);
    tick;
    run(MODE_ADDW, 16'h7FFF, 16'h0001, lat, rl);
    chk("addw_result", bus.result, 16'h8000);
    chk("addw_flags_nzvc", flags(), 4'b1010);
    tick;
    bus.start = 1'b1;
    bus.mode = MODE_ADD;
    bus.a = 16'h0100;
    bus.b = 16'h0023;
    tick;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      bus.a = 16'h1111 * 16'(i + 1);
      bus.b = 16'h0F0F + 16'(i);
      tick;
      if (bus.done === 1'b1) ndone++;
    end
    chk("hold_start_one_done", ndone, 1);
    chk("hold_start_result", bus.result, 16'h0123);
    bus.a = 16'h0005;
    bus.b = 16'h0006;
    tick;
    chk("hold_start_no_redone", bus.done, 0);
    chk("hold_start_idle", bus.ready, 1);
    tick;
    chk("hold_start_accepted", bus.ready, 0);
    bus.start = 1'b0;
    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      tick;
      lat++;
    end
    chk("second_op_latency", lat, 4);
    chk("second_op_result", bus.result, 16'h000B);
    chk("second_op_flags", flags(), 4'b0000);
    tick;
    bus.start = 1'b1;
    bus.mode = MODE_ADD;
    bus.a = 16'h1111;
    bus.b = 16'h1111;
    tick;
    bus.start = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_ready", bus.ready, 1);
    chk("abort_done", bus.done, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_flags", flags(), 4'b0000);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (bus.done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
